// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_hazard_ctrl.
//
// Datapath -> controller:
//   id_rs1, id_rs2, id_uses_rs1, id_uses_rs2  source operands of the instruction in ID
//   ex_rd, ex_mem_read, ex_branch_taken       destination, load flag, taken flag of EX
//   mem_busy                                  data memory still busy this cycle
//   halt_req                                  ecall/ebreak decoded in ID
// Controller -> datapath:
//   pc_load, ifid_load, ifid_flush, idex_load, idex_flush, exmem_load, memwb_load
//
// master: datapath side, slave: hazard controller.
interface pipeline_hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_branch_taken;
    logic       mem_busy;
    logic       halt_req;

    logic       pc_load;
    logic       ifid_load;
    logic       ifid_flush;
    logic       idex_load;
    logic       idex_flush;
    logic       exmem_load;
    logic       memwb_load;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_busy, halt_req,
        input  pc_load, ifid_load, ifid_flush, idex_load, idex_flush,
               exmem_load, memwb_load
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_busy, halt_req,
        output pc_load, ifid_load, ifid_flush, idex_load, idex_flush,
               exmem_load, memwb_load
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for the pipelined RISC-V core.
// Generates load/flush enables for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// Event priority in RUN: memory wait (freeze) > taken branch (flush) >
// load-use hazard (one bubble) > halt request (drain).
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   hz         hazard bundle (slave modport), see pipeline_hazard_ctrl_if
//   halted     core has drained and stopped (registered)
//   stall_cnt  saturating count of load-use stall cycles
//   flush_cnt  saturating count of branch flush events
//
// State table:
//   S_RUN    | normal operation, hazards resolved by priority
//   S_DRAIN  | halt seen; fetch squashed, older instructions retire
//   S_HALTED | pipeline frozen, halted=1 until reset
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave hz,
    output logic                 halted,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              lu_hazard;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign lu_hazard = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                       ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                        (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

    always_comb begin
        hz.pc_load    = 1'b1;
        hz.ifid_load  = 1'b1;
        hz.ifid_flush = 1'b0;
        hz.idex_load  = 1'b1;
        hz.idex_flush = 1'b0;
        hz.exmem_load = 1'b1;
        hz.memwb_load = 1'b1;
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;

        case (state_q)
            S_RUN: begin
                if (hz.mem_busy) begin
                    hz.pc_load    = 1'b0;
                    hz.ifid_load  = 1'b0;
                    hz.idex_load  = 1'b0;
                    hz.exmem_load = 1'b0;
                    hz.memwb_load = 1'b0;
                end else if (hz.ex_branch_taken) begin
                    // Younger instructions in IF and ID are wrong-path; their
                    // hazards and halt requests are discarded with them.
                    hz.ifid_flush = 1'b1;
                    hz.idex_flush = 1'b1;
                    if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end else if (lu_hazard) begin
                    hz.pc_load    = 1'b0;
                    hz.ifid_load  = 1'b0;
                    hz.idex_flush = 1'b1;
                    if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end else if (hz.halt_req) begin
                    hz.pc_load    = 1'b0;
                    hz.ifid_flush = 1'b1;
                    state_d       = S_DRAIN;
                    drain_cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                if (hz.mem_busy) begin
                    hz.pc_load    = 1'b0;
                    hz.ifid_load  = 1'b0;
                    hz.idex_load  = 1'b0;
                    hz.exmem_load = 1'b0;
                    hz.memwb_load = 1'b0;
                end else begin
                    hz.pc_load    = 1'b0;
                    hz.ifid_flush = 1'b1;
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d = S_HALTED;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DW'(1);
                    end
                end
            end
            default: begin
                hz.pc_load    = 1'b0;
                hz.ifid_load  = 1'b0;
                hz.idex_load  = 1'b0;
                hz.exmem_load = 1'b0;
                hz.memwb_load = 1'b0;
            end
        endcase

        halted_d = (state_d == S_HALTED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            drain_cnt_q <= '0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halted    = halted_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    // {pc_load, ifid_load, ifid_flush, idex_load, idex_flush, exmem_load, memwb_load}
    localparam logic [6:0] C_IDLE   = 7'b1101011;
    localparam logic [6:0] C_FREEZE = 7'b0000000;
    localparam logic [6:0] C_BRANCH = 7'b1111111;
    localparam logic [6:0] C_STALL  = 7'b0001111;
    localparam logic [6:0] C_HALT   = 7'b0111011;
    localparam logic [6:0] C_DRAIN  = 7'b0111011;

    logic             clk = 1'b0;
    logic             rst;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [6:0]       ctl;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .hz        (bus.slave),
        .halted    (halted),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    assign ctl = {bus.pc_load, bus.ifid_load, bus.ifid_flush, bus.idex_load,
                  bus.idex_flush, bus.exmem_load, bus.memwb_load};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        bus.id_rs1          = 5'd0;
        bus.id_rs2          = 5'd0;
        bus.id_uses_rs1     = 1'b0;
        bus.id_uses_rs2     = 1'b0;
        bus.ex_rd           = 5'd0;
        bus.ex_mem_read     = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.mem_busy        = 1'b0;
        bus.halt_req        = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lu_rs2(input logic [4:0] r);
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = r;
        bus.id_rs2      = r;
        bus.id_uses_rs2 = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_ctl", ctl, C_IDLE);
        chk("reset_halted", halted, 0);
        chk("reset_stall", stall_cnt, 0);
        chk("reset_flush", flush_cnt, 0);
        step();
        chk("idle_ctl", ctl, C_IDLE);

        // load-use on rs2
        lu_rs2(5'd5);
        #1 chk("lu_rs2_ctl", ctl, C_STALL);
        step();
        chk("lu_rs2_cnt", stall_cnt, 1);
        clear_in();

        // same pattern on x0 must not stall
        lu_rs2(5'd0);
        #1 chk("lu_x0_ctl", ctl, C_IDLE);
        step();
        chk("lu_x0_cnt", stall_cnt, 1);
        clear_in();

        // load-use on rs1
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; bus.id_uses_rs1 = 1'b1;
        #1 chk("lu_rs1_ctl", ctl, C_STALL);
        step();
        chk("lu_rs1_cnt", stall_cnt, 2);
        // matching register that is not read: no hazard
        bus.id_uses_rs1 = 1'b0;
        #1 chk("lu_unused_ctl", ctl, C_IDLE);
        step();
        chk("lu_unused_cnt", stall_cnt, 2);
        clear_in();

        // branch beats load-use
        lu_rs2(5'd9);
        bus.ex_branch_taken = 1'b1;
        #1 chk("br_lu_ctl", ctl, C_BRANCH);
        step();
        chk("br_lu_flush", flush_cnt, 1);
        chk("br_lu_stall", stall_cnt, 2);
        clear_in();

        // mem_busy freezes a pending branch for 3 cycles
        bus.ex_branch_taken = 1'b1;
        bus.mem_busy        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("busy_br_ctl", ctl, C_FREEZE);
            step();
            chk("busy_br_flush", flush_cnt, 1);
        end
        bus.mem_busy = 1'b0;
        #1 chk("br_release_ctl", ctl, C_BRANCH);
        step();
        chk("br_release_flush", flush_cnt, 2);
        clear_in();

        // halt: 1 edge to enter DRAIN, 3 advancing, 2 frozen
        bus.halt_req = 1'b1;
        #1 chk("halt_ctl", ctl, C_HALT);
        step();
        clear_in();
        // wrong-path events in DRAIN are ignored
        bus.ex_branch_taken = 1'b1;
        lu_rs2(5'd3);
        bus.halt_req = 1'b1;
        #1 chk("drain0_ctl", ctl, C_DRAIN);
        chk("drain0_halted", halted, 0);
        step();
        clear_in();
        bus.mem_busy = 1'b1;
        #1 chk("drain_busy_ctl", ctl, C_FREEZE);
        step();
        step();
        bus.mem_busy = 1'b0;
        #1 chk("drain1_ctl", ctl, C_DRAIN);
        step();
        chk("drain2_halted", halted, 0);
        step();
        chk("halted_set", halted, 1);
        chk("drain_stall", stall_cnt, 2);
        chk("drain_flush", flush_cnt, 2);
        bus.ex_branch_taken = 1'b1;
        #1 chk("halted_ctl", ctl, C_FREEZE);
        step();
        chk("halted_hold", halted, 1);
        clear_in();

        // reset leaves HALTED
        #1 rst = 1'b1;
        #1 chk("rst_halted", halted, 0);
        chk("rst_flush", flush_cnt, 0);
        step();
        rst = 1'b0;
        #1 chk("rst_ctl", ctl, C_IDLE);

        // saturation at 2^CNT_W-1
        lu_rs2(5'd12);
        repeat (20) step();
        chk("stall_sat", stall_cnt, 15);
        clear_in();

        // reset mid-DRAIN
        bus.halt_req = 1'b1;
        step();
        clear_in();
        step();
        chk("mid_drain_ctl", ctl, C_DRAIN);
        #1 rst = 1'b1;
        #1 chk("mid_rst_stall", stall_cnt, 0);
        chk("mid_rst_halted", halted, 0);
        step();
        rst = 1'b0;
        #1 chk("mid_rst_ctl", ctl, C_IDLE);
        lu_rs2(5'd4);
        #1 chk("post_rst_lu_ctl", ctl, C_STALL);
        step();
        chk("post_rst_lu_cnt", stall_cnt, 1);
        clear_in();
        step();
        step();
        chk("post_rst_no_halt", halted, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
